// File: rtl/move_queue_if.sv
// Handshake bundle between the user-input front end (move_queue) and its surroundings.
// The slave modport is the move_queue side; the master modport drives the raw inputs and the ready signal.
interface move_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [3:0]       sw;
    logic             key_n;
    logic             err_clr;
    logic             move_ready;
    logic             move_valid;
    logic [3:0]       move_code;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             err_overflow;
    logic             err_invalid;

    modport master (
        output sw, key_n, err_clr, move_ready,
        input  move_valid, move_code, count, full, err_overflow, err_invalid
    );

    modport slave (
        input  sw, key_n, err_clr, move_ready,
        output move_valid, move_code, count, full, err_overflow, err_invalid
    );
endinterface

// File: rtl/move_queue.sv
// Turns a bouncy move button plus move-select switches into one queued, legality-checked
// move command per press, delivered to the cube logic over a valid/ready handshake.
module move_queue #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEPTH           = 4
) (
    input  logic         clk,
    input  logic         reset,
    move_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic             r_key_s1, r_key_s2;
    logic [3:0]       r_sw_s1, r_sw_s2;
    logic             r_stable;
    logic [DB_W-1:0]  r_db_cnt;
    logic [3:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_err_ovf, r_err_inv;

    logic w_differ, w_accept, w_press, w_legal, w_valid, w_pop, w_room;
    logic w_push, w_set_ovf, w_set_inv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1 <= 1'b1;
            r_key_s2 <= 1'b1;
            r_sw_s1  <= 4'd0;
            r_sw_s2  <= 4'd0;
        end else begin
            r_key_s1 <= bus.key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= bus.sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    // Any edge where the synchronised key agrees with the stable level restarts the count.
    assign w_differ = (r_key_s2 != r_stable);
    assign w_accept = w_differ && (r_db_cnt == DB_LAST);
    assign w_press  = w_accept && r_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b1;
            r_db_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= r_key_s2;
            r_db_cnt <= '0;
        end else if (w_differ) begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_legal   = (r_sw_s2 < 4'd12);
    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && bus.move_ready;
    assign w_room    = (r_count != CNT_FULL) || w_pop;
    assign w_push    = w_press && w_legal && w_room;
    assign w_set_ovf = w_press && w_legal && !w_room;
    assign w_set_inv = w_press && !w_legal;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_sw_s2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error on the same edge as err_clr must survive the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_inv <= 1'b0;
        end else begin
            if (w_set_ovf)        r_err_ovf <= 1'b1;
            else if (bus.err_clr) r_err_ovf <= 1'b0;
            if (w_set_inv)        r_err_inv <= 1'b1;
            else if (bus.err_clr) r_err_inv <= 1'b0;
        end
    end

    // Head code is masked while empty so the unreset storage never leaks out after reset.
    assign bus.move_valid   = w_valid;
    assign bus.move_code    = w_valid ? r_mem[r_rd_ptr] : 4'd0;
    assign bus.count        = r_count;
    assign bus.full         = (r_count == CNT_FULL);
    assign bus.err_overflow = r_err_ovf;
    assign bus.err_invalid  = r_err_inv;
endmodule

// File: tb/tb_move_queue.sv
// Directed bench for move_queue: a queue-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_move_queue;
    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    bit   started = 1'b0;
    int   checks = 0;
    int   errors = 0;

    move_queue_if #(.DEPTH(DEPTH)) bus ();

    move_queue #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: two-sample input delay, a press is DB consecutive low samples
    // while released, and a plain queue of codes.
    logic [3:0] mq[$];
    bit         win[$];
    bit         m_ovf, m_inv, m_stable, k0, k1, ks, pop, press, alldiff;
    logic [3:0] s0, s1, ss;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete(); win.delete();
            m_ovf = 0; m_inv = 0; m_stable = 1;
            k0 = 1; k1 = 1; s0 = 4'd0; s1 = 4'd0;
        end else begin
            ks = k1; ss = s1;
            k1 = k0; k0 = bus.key_n;
            s1 = s0; s0 = bus.sw;
            win.push_back(ks);
            if (win.size() > DB) void'(win.pop_front());
            pop   = (mq.size() != 0) && bus.move_ready;
            press = 0;
            if (win.size() == DB) begin
                alldiff = 1;
                foreach (win[i]) if (win[i] == m_stable) alldiff = 0;
                if (alldiff) begin
                    press    = m_stable;
                    m_stable = !m_stable;
                    win.delete();
                end
            end
            if (bus.err_clr) begin m_ovf = 0; m_inv = 0; end
            if (pop) void'(mq.pop_front());
            if (press) begin
                if (ss >= 4'd12)           m_inv = 1;
                else if (mq.size() < DEPTH) mq.push_back(ss);
                else                        m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (bus.move_valid !== (mq.size() != 0) || bus.count !== 3'(mq.size()) ||
                bus.full !== (mq.size() == DEPTH) || bus.err_overflow !== m_ovf ||
                bus.err_invalid !== m_inv) begin
                errors++;
                $display("FAIL model t=%0t got v=%b cnt=%0d full=%b ovf=%b inv=%b required v=%b cnt=%0d full=%b ovf=%b inv=%b",
                         $time, bus.move_valid, bus.count, bus.full, bus.err_overflow, bus.err_invalid,
                         mq.size() != 0, mq.size(), mq.size() == DEPTH, m_ovf, m_inv);
            end
            if (mq.size() != 0) begin
                checks++;
                if (bus.move_code !== mq[0]) begin
                    errors++;
                    $display("FAIL model_code t=%0t got %0d required %0d", $time, bus.move_code, mq[0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic press_code(input logic [3:0] code);
        bus.sw = code; bus.key_n = 1'b0;
        tick(8);
        bus.key_n = 1'b1;
        tick(8);
    endtask

    task automatic pop_one();
        bus.move_ready = 1'b1;
        tick(1);
        bus.move_ready = 1'b0;
    endtask

    initial begin
        bus.sw = 4'd0; bus.key_n = 1'b1; bus.err_clr = 1'b0; bus.move_ready = 1'b0;
        #3 reset = 1'b1;
        started = 1'b1;
        tick(2);
        chk("rst_valid", 8'(bus.move_valid), 8'd0);
        chk("rst_count", 8'(bus.count), 8'd0);
        chk("rst_code", 8'(bus.move_code), 8'd0);
        reset = 1'b0;

        // Clean press, first sampled on edge 1, event on edge 6
        bus.sw = 4'd5; bus.key_n = 1'b0;
        tick(5);
        chk("t1_valid_e5", 8'(bus.move_valid), 8'd0);
        tick(1);
        chk("t1_valid_e6", 8'(bus.move_valid), 8'd1);
        chk("t1_code", 8'(bus.move_code), 8'd5);
        chk("t1_count", 8'(bus.count), 8'd1);
        tick(100);
        chk("t1_hold_count", 8'(bus.count), 8'd1);
        bus.key_n = 1'b1;
        tick(8);
        pop_one();
        chk("t1_pop_count", 8'(bus.count), 8'd0);
        chk("t1_pop_valid", 8'(bus.move_valid), 8'd0);

        // Bounce for 20 cycles, then settle low
        bus.sw = 4'd2;
        for (int i = 0; i < 10; i++) begin
            bus.key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        chk("t2_no_event", 8'(bus.count), 8'd0);
        bus.key_n = 1'b0;
        tick(5);
        chk("t2_before", 8'(bus.count), 8'd0);
        tick(1);
        chk("t2_event", 8'(bus.count), 8'd1);
        tick(30);
        chk("t2_single", 8'(bus.count), 8'd1);
        bus.key_n = 1'b1;
        tick(8);
        pop_one();

        // Illegal code
        press_code(4'd13);
        chk("t3_count", 8'(bus.count), 8'd0);
        chk("t3_inv", 8'(bus.err_invalid), 8'd1);
        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        chk("t3_inv_clr", 8'(bus.err_invalid), 8'd0);

        // Overflow on the fifth press, then drain in order
        for (int c = 0; c < 5; c++) press_code(4'(c));
        chk("t4_count", 8'(bus.count), 8'd4);
        chk("t4_full", 8'(bus.full), 8'd1);
        chk("t4_ovf", 8'(bus.err_overflow), 8'd1);
        for (int c = 0; c < 4; c++) begin
            chk("t4_pop_code", 8'(bus.move_code), 8'(c));
            pop_one();
        end
        chk("t4_empty", 8'(bus.count), 8'd0);
        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        chk("t4_ovf_clr", 8'(bus.err_overflow), 8'd0);

        // Full queue, push coincides with a pop
        for (int c = 1; c <= 4; c++) press_code(4'(c));
        bus.sw = 4'd7; bus.key_n = 1'b0;
        tick(5);
        bus.move_ready = 1'b1;
        tick(1);
        bus.move_ready = 1'b0;
        chk("t5_count", 8'(bus.count), 8'd4);
        chk("t5_full", 8'(bus.full), 8'd1);
        chk("t5_ovf", 8'(bus.err_overflow), 8'd0);
        bus.key_n = 1'b1;
        tick(8);
        // Overflow on the same edge as err_clr: set wins
        bus.sw = 4'd9; bus.key_n = 1'b0;
        tick(5);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        chk("t5_set_wins", 8'(bus.err_overflow), 8'd1);
        bus.key_n = 1'b1;
        tick(8);
        chk("t5_head2", 8'(bus.move_code), 8'd2); pop_one();
        chk("t5_head3", 8'(bus.move_code), 8'd3); pop_one();
        chk("t5_head4", 8'(bus.move_code), 8'd4); pop_one();
        chk("t5_head7", 8'(bus.move_code), 8'd7); pop_one();
        chk("t5_drained", 8'(bus.count), 8'd0);

        // Reset mid-debounce with a queued entry and a sticky flag set
        press_code(4'd3);
        bus.key_n = 1'b0;
        tick(4);
        reset = 1'b1;
        #1;
        chk("t6_valid", 8'(bus.move_valid), 8'd0);
        chk("t6_count", 8'(bus.count), 8'd0);
        chk("t6_full", 8'(bus.full), 8'd0);
        chk("t6_ovf", 8'(bus.err_overflow), 8'd0);
        chk("t6_inv", 8'(bus.err_invalid), 8'd0);
        chk("t6_code", 8'(bus.move_code), 8'd0);
        tick(1);
        reset = 1'b0;
        tick(5);
        chk("t6_before", 8'(bus.count), 8'd0);
        tick(1);
        chk("t6_again", 8'(bus.count), 8'd1);
        chk("t6_again_code", 8'(bus.move_code), 8'd3);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
